// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store unit between EX/MEM and MEM/WB.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
package mem_lsu_pkg;
  typedef logic [7:0] AluOpBus;
  localparam AluOpBus EXE_LB_OP  = 8'hE0;
  localparam AluOpBus EXE_LH_OP  = 8'hE1;
  localparam AluOpBus EXE_LW_OP  = 8'hE3;
  localparam AluOpBus EXE_LBU_OP = 8'hE4;
  localparam AluOpBus EXE_LHU_OP = 8'hE5;
  localparam AluOpBus EXE_SB_OP  = 8'hE8;
  localparam AluOpBus EXE_SH_OP  = 8'hE9;
  localparam AluOpBus EXE_SW_OP  = 8'hEB;
endpackage

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  AluOpBus           aluop_i,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic              stall_i,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              bus_err_o,
  output logic              misalign_o
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  state_e state_q, state_d;

  logic        is_mem, is_ld, dec_uns, dec_mis;
  logic [1:0]  dec_sz;
  logic [3:0]  dec_sel;
  logic [31:0] dec_wd;
  logic [1:0]  a_lo;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       wd_q, rdata_q;
  logic              bwe_q, ld_q, uns_q, err_q;
  logic [1:0]        sz_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              to_hit, mis_w;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_data;

  assign a_lo = mem_addr_i[1:0];

  always_comb begin
    is_mem  = 1'b1;
    is_ld   = 1'b1;
    dec_uns = 1'b0;
    dec_sz  = SZ_W;
    unique case (1'b1)
      (aluop_i == EXE_LB_OP):  dec_sz = SZ_B;
      (aluop_i == EXE_LBU_OP): begin
        dec_sz  = SZ_B;
        dec_uns = 1'b1;
      end
      (aluop_i == EXE_LH_OP):  dec_sz = SZ_H;
      (aluop_i == EXE_LHU_OP): begin
        dec_sz  = SZ_H;
        dec_uns = 1'b1;
      end
      (aluop_i == EXE_LW_OP):  dec_sz = SZ_W;
      (aluop_i == EXE_SB_OP):  begin
        dec_sz = SZ_B;
        is_ld  = 1'b0;
      end
      (aluop_i == EXE_SH_OP):  begin
        dec_sz = SZ_H;
        is_ld  = 1'b0;
      end
      (aluop_i == EXE_SW_OP):  is_ld = 1'b0;
      default:                 is_mem = 1'b0;
    endcase
  end

  // Big-endian lanes: sel[3] is the byte at offset 0
  always_comb begin
    dec_sel = 4'b1111;
    dec_wd  = mem_data_i;
    unique case (dec_sz)
      SZ_B: begin
        dec_sel = 4'b1000 >> a_lo;
        dec_wd  = {4{mem_data_i[7:0]}};
      end
      SZ_H: begin
        dec_sel = a_lo[1] ? 4'b0011 : 4'b1100;
        dec_wd  = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign dec_mis = ((dec_sz == SZ_H) && a_lo[0])
                || ((dec_sz == SZ_W) && (a_lo != 2'b00));
  assign mis_w   = mis_q;
`else
  assign dec_mis = 1'b0;
  assign mis_w   = 1'b0;
`endif

  assign cnt_d  = cnt_q + 1'b1;
  assign to_hit = (TIMEOUT != 0) && (cnt_d == TO_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (is_mem) state_d = dec_mis ? DONE : REQ;
      REQ:  if (bus_ack_i || to_hit) state_d = DONE;
      DONE: if (!stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      sel_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      bwe_q   <= 1'b0;
      ld_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      sz_q    <= SZ_W;
      cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (is_mem) begin
          addr_q <= mem_addr_i;
          sel_q  <= dec_sel;
          wd_q   <= dec_wd;
          bwe_q  <= ~is_ld;
          ld_q   <= is_ld;
          uns_q  <= dec_uns;
          sz_q   <= dec_sz;
          err_q  <= 1'b0;
          cnt_q  <= '0;
`ifdef MISALIGN_TRAP_EN
          mis_q  <= dec_mis;
`endif
        end
        REQ: begin
          cnt_q <= cnt_d;
          if (bus_ack_i) rdata_q <= bus_rdata_i;
          else if (to_hit) err_q <= 1'b1;
        end
        DONE: if (!stall_i) begin
          err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          mis_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_b = rdata_q[7:0];
    unique case (addr_q[1:0])
      2'b00:   ld_b = rdata_q[31:24];
      2'b01:   ld_b = rdata_q[23:16];
      2'b10:   ld_b = rdata_q[15:8];
      default: ld_b = rdata_q[7:0];
    endcase
    ld_h = addr_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (sz_q)
      SZ_B:    ld_data = {{24{ld_b[7] & ~uns_q}}, ld_b};
      SZ_H:    ld_data = {{16{ld_h[15] & ~uns_q}}, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    waddr_o    = waddr_i;
    we_o       = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_mem) stallreq_o = 1'b1;
        else begin
          we_o    = we_i;
          wdata_o = wdata_i;
        end
      end
      REQ:  stallreq_o = 1'b1;
      DONE: if (ld_q && !err_q && !mis_w) begin
        we_o    = we_i;
        wdata_o = ld_data;
      end
      default: ;
    endcase
    if (!rst) begin
      waddr_o = '0;
      we_o    = 1'b0;
      wdata_o = '0;
    end
  end

  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = bus_req_o & bwe_q;
  assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = wd_q;
  assign bus_err_o   = err_q;
  assign misalign_o  = mis_w;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu lanes, timing, timeout, reset.
// Built with TIMEOUT=4 so the abort path is reached quickly.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  AluOpBus     aluop_i = 8'h00;
  logic [4:0]  waddr_i = 5'd9;
  logic        we_i = 1'b1;
  logic [31:0] wdata_i = 32'h5555_5555;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        stall_i = 1'b0;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_o, misalign_o;

  int n_run  = 0;
  int n_fail = 0;

  mem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i),
    .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .stall_i(stall_i), .waddr_o(waddr_o), .we_o(we_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one op, acks after `waits` REQ cycles, returns in DONE.
  task automatic access(input AluOpBus op,
                        input logic [31:0] a, d, rd,
                        input int waits,
                        output int nstall, nreq,
                        output logic [3:0] sel,
                        output logic [31:0] addr, wd,
                        output logic bwe);
    bit done;
    done = 0; nstall = 0; nreq = 0;
    sel = '0; addr = '0; wd = '0; bwe = 1'b0;
    @(negedge clk);
    aluop_i = op; mem_addr_i = a; mem_data_i = d;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stallreq_o) done = 1;
      else begin
        nstall++;
        if (bus_req_o) begin
          if (nreq == 0) begin
            sel = bus_sel_o; addr = bus_addr_o;
            wd = bus_wdata_o; bwe = bus_we_o;
          end
          nreq++;
          if (nreq > waits) begin
            bus_ack_i = 1'b1; bus_rdata_i = rd;
          end
        end
        @(negedge clk);
        bus_ack_i = 1'b0; bus_rdata_i = '0;
      end
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
  endtask

  int ns, nr;
  logic [3:0] s;
  logic [31:0] ad, wd;
  logic bw;

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_req", bus_req_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_mis", misalign_o, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("nop_we", we_o, 1);
    chk("nop_wdata", wdata_o, 32'h5555_5555);
    chk("nop_waddr", waddr_o, 9);
    chk("nop_stall", stallreq_o, 0);

    access(EXE_LW_OP, 32'h8000_0010, 0, 32'hDEAD_BEEF, 3,
           ns, nr, s, ad, wd, bw);
    chk("lw_stall", ns, 5);
    chk("lw_sel", s, 4'b1111);
    chk("lw_addr", ad, 32'h8000_0010);
    chk("lw_bwe", bw, 0);
    chk("lw_data", wdata_o, 32'hDEAD_BEEF);
    chk("lw_we", we_o, 1);

    access(EXE_LB_OP, 32'h8000_0003, 0, 32'h0000_00F0, 0,
           ns, nr, s, ad, wd, bw);
    chk("lb_stall", ns, 2);
    chk("lb_sel", s, 4'b0001);
    chk("lb_data", wdata_o, 32'hFFFF_FFF0);

    access(EXE_LBU_OP, 32'h8000_0003, 0, 32'h0000_00F0, 0,
           ns, nr, s, ad, wd, bw);
    chk("lbu_data", wdata_o, 32'h0000_00F0);

    access(EXE_LBU_OP, 32'h8000_0001, 0, 32'h11A5_2233, 1,
           ns, nr, s, ad, wd, bw);
    chk("lbu1_sel", s, 4'b0100);
    chk("lbu1_stall", ns, 3);
    chk("lbu1_data", wdata_o, 32'h0000_00A5);

    access(EXE_LH_OP, 32'h8000_0000, 0, 32'h8001_2345, 0,
           ns, nr, s, ad, wd, bw);
    chk("lh_sel", s, 4'b1100);
    chk("lh_data", wdata_o, 32'hFFFF_8001);

    access(EXE_LHU_OP, 32'h8000_0002, 0, 32'h1234_8001, 0,
           ns, nr, s, ad, wd, bw);
    chk("lhu_sel", s, 4'b0011);
    chk("lhu_data", wdata_o, 32'h0000_8001);

    access(EXE_SH_OP, 32'h8000_0002, 32'h1234_ABCD, 0, 0,
           ns, nr, s, ad, wd, bw);
    chk("sh_bwe", bw, 1);
    chk("sh_sel", s, 4'b0011);
    chk("sh_wd", wd, 32'hABCD_ABCD);
    chk("sh_addr", ad, 32'h8000_0000);
    chk("sh_we", we_o, 0);

    access(EXE_SB_OP, 32'h8000_0001, 32'h0000_00A5, 0, 0,
           ns, nr, s, ad, wd, bw);
    chk("sb_sel", s, 4'b0100);
    chk("sb_wd", wd, 32'hA5A5_A5A5);
    chk("sb_we", we_o, 0);

    access(EXE_LW_OP, 32'h8000_0006, 0, 32'hCAFE_F00D, 0,
           ns, nr, s, ad, wd, bw);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", nr, 0);
    chk("mis_flag", misalign_o, 1);
    chk("mis_we", we_o, 0);
    chk("mis_stall", ns, 1);
`else
    chk("mis_req", nr, 1);
    chk("mis_addr", ad, 32'h8000_0004);
    chk("mis_sel", s, 4'b1111);
    chk("mis_flag", misalign_o, 0);
    chk("mis_data", wdata_o, 32'hCAFE_F00D);
`endif

    access(EXE_LW_OP, 32'h8000_0040, 0, 32'h1111_1111, 100,
           ns, nr, s, ad, wd, bw);
    chk("to_reqcyc", nr, 4);
    chk("to_err", bus_err_o, 1);
    chk("to_we", we_o, 0);
    chk("to_wdata", wdata_o, 0);
    @(negedge clk); aluop_i = 8'h00; #1;
    chk("to_idle_err", bus_err_o, 0);
    chk("to_idle_we", we_o, 1);

    @(negedge clk);
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h8000_0030;
    @(negedge clk); #1;
    chk("rq_req_hi", bus_req_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rq_req_drop", bus_req_o, 0);
    chk("rq_we", we_o, 0);
    @(negedge clk); aluop_i = 8'h00; rst = 1'b1; #1;
    chk("rq_idle_stall", stallreq_o, 0);
    chk("rq_idle_we", we_o, 1);

    stall_i = 1'b1;
    access(EXE_LW_OP, 32'h8000_0020, 0, 32'h0BAD_F00D, 0,
           ns, nr, s, ad, wd, bw);
    chk("st_d1_data", wdata_o, 32'h0BAD_F00D);
    chk("st_d1_we", we_o, 1);
    @(negedge clk); #1;
    chk("st_d2_data", wdata_o, 32'h0BAD_F00D);
    chk("st_d2_stall", stallreq_o, 0);
    chk("st_d2_req", bus_req_o, 0);
    @(negedge clk); #1;
    chk("st_d3_data", wdata_o, 32'h0BAD_F00D);
    stall_i = 1'b0; aluop_i = 8'h00;
    @(negedge clk); #1;
    chk("st_idle_data", wdata_o, 32'h5555_5555);
    chk("st_idle_stall", stallreq_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Multi-cycle load/store unit replacing the single-cycle MEM-stage access path. It sits between EX/MEM and MEM/WB. It issues byte, halfword and word accesses to a variable-latency memory bus through a req/ack handshake, and stalls the pipeline until the access completes or times out. It adds unsigned/halfword loads, halfword stores and a bus timeout. Non-memory ops pass through combinationally.

## Interface
- `ADDR_W`, 32, bus address width; `mem_addr_i[ADDR_W-1:0]` is used.
- `TIMEOUT`, 255, max REQ cycles without ack before abort; 0 disables timeout.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `aluop_i`  in  `AluOpBus`  op: `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP`; anything else is non-memory.
- `waddr_i` / `we_i` / `wdata_i`  in  5/1/32  writeback request from EX.
- `mem_addr_i` / `mem_data_i`  in  32/32  effective address, store data.
- `stall_i`  in  1  downstream stall; holds MEM/WB.
- `waddr_o` / `we_o` / `wdata_o`  out  5/1/32  writeback to MEM/WB.
- `stallreq_o`  out  1  freeze IF..EX/MEM.
- `bus_req_o`, `bus_we_o`  out  1  request, write strobe.
- `bus_addr_o`  out  ADDR_W  word-aligned address (`[1:0]`=00).
- `bus_sel_o`  out  4  byte lanes, big-endian (`sel[3]` = `addr[1:0]`==00).
- `bus_wdata_o`  out  32  store data, replicated into lanes.
- `bus_ack_i`  in  1  access complete; `bus_rdata_i`  in  32  load data, valid with ack.
- `bus_err_o`  out  1  timeout indication.
- `misalign_o`  out  1  misaligned-access indication.

## Operation
- FSM states: IDLE, REQ, DONE. Reset: IDLE. All bus outputs, `bus_err_o`, `misalign_o` and the capture registers are 0. `waddr_o`/`we_o`/`wdata_o` are 0 while `rst` is low.
- IDLE, non-memory op: `waddr_o`/`we_o`/`wdata_o` = inputs; `stallreq_o`=0.
- IDLE, memory op: `stallreq_o`=1, `we_o`=0. Latch addr, sel, wdata, we and load type. Next state: REQ (or DONE if misaligned, see Configuration).
- REQ: `bus_req_o`=1. Address, sel, wdata and we are held stable until ack. `stallreq_o`=1, `we_o`=0. The REQ-cycle counter increments each cycle.
  - On `bus_ack_i`: capture `bus_rdata_i`, go to DONE.
  - On counter == `TIMEOUT` (TIMEOUT≠0) without ack: drop req, set error flag, go to DONE.
- DONE: `stallreq_o`=0, `bus_req_o`=0.
  - Loads: `we_o`=`we_i` and `wdata_o`=extracted data. Stores: `we_o`=0.
  - Error or misalign: `we_o`=0, `wdata_o`=0, and `bus_err_o` or `misalign_o`=1.
  - Leave to IDLE when `stall_i`=0; otherwise hold DONE with outputs stable.
- Lane mapping:
  - Byte: `addr[1:0]` 00→sel 1000, data[31:24]; 01→0100, [23:16]; 10→0010, [15:8]; 11→0001, [7:0].
  - Half: `addr[1]`=0→1100, [31:16]; `addr[1]`=1→0011, [15:0].
  - Word: 1111.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store data: SB replicates byte ×4, SH replicates half ×2, SW unchanged.
- Ack in IDLE/DONE is ignored.

## Timing
- Access with ack in first REQ cycle: stall for 2 cycles (IDLE, REQ); result in DONE on the 3rd cycle.
- Each added wait cycle adds 1.
- Timeout: abort after exactly `TIMEOUT` REQ cycles; DONE follows on the next cycle.
- Non-memory ops: 0 added latency.
- Back-to-back memory ops: DONE→IDLE, new op detected in IDLE; there is no req overlap.
- `rst` low at any time: immediate return to IDLE, `bus_req_o` drops asynchronously, and an in-flight access is discarded.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, skip REQ.
  - IDLE→DONE with `misalign_o`=1, `we_o`=0, and no bus request.
- Undefined:
  - Offending low address bits are treated as 0: half uses `addr[1]`, word uses the aligned word.
  - `misalign_o` is tied 0.

## Test plan
- LW at 0x80000010, ack after 3 wait cycles, rdata 0xDEADBEEF: `bus_sel_o`=1111; `stallreq_o` high 5 cycles; DONE `wdata_o`=0xDEADBEEF with `we_o`=1.
- LB / LBU at 0x80000003 with rdata 0x000000F0: sel 0001; `wdata_o`=0xFFFFFFF0 for LB and 0x000000F0 for LBU.
- SH at 0x80000002, data 0x1234ABCD: `bus_we_o`=1, sel 0011, `bus_wdata_o`=0xABCDABCD, `bus_addr_o`=0x80000000; DONE `we_o`=0.
- TIMEOUT=4, no ack: `bus_req_o` high exactly 4 cycles; then DONE with `bus_err_o`=1, `we_o`=0; then IDLE.
- LW at 0x80000006: with `MISALIGN_TRAP_EN`, no `bus_req_o` and `misalign_o`=1 in the cycle after. Without it, a word access at 0x80000004.
- `rst` pulsed low mid-REQ, then `stall_i` held high 2 cycles in DONE of a following load: `bus_req_o` drops at once and state is IDLE; DONE outputs stay stable for 2 cycles, then IDLE.
